// File: rtl/disp_wta_seq_pkg.sv
// disp_wta_seq_pkg: shared stereo constants, cost/disparity width helpers and WTA FSM states.
package disp_wta_seq_pkg;
    localparam int WC_DEF = 3;
    localparam int WH_DEF = 7;
    localparam int D_DEF  = 64;

    function automatic int cost_bits(input int wc, input int wh);
        return $clog2(((wc ** 2) / 2) * (wh ** 2));
    endfunction

    function automatic int disp_bits(input int d);
        return $clog2(d);
    endfunction

    typedef enum logic {ACCUM, OUT} state_t;
endpackage

// File: rtl/disp_wta_seq_cmp.sv
// disp_cmp: two-candidate cost comparator; strict less-than so ties keep candidate 1.
module disp_cmp
    import disp_wta_seq_pkg::*;
#(
    parameter int WC = WC_DEF,
    parameter int WH = WH_DEF,
    parameter int D  = D_DEF,
    localparam int CBIT = cost_bits(WC, WH),
    localparam int DBIT = disp_bits(D)
) (
    input  logic [CBIT-1:0] c1,
    input  logic [DBIT-1:0] d1,
    input  logic [CBIT-1:0] c2,
    input  logic [DBIT-1:0] d2,
    output logic [CBIT-1:0] c,
    output logic [DBIT-1:0] d
);
    logic lt;
    assign lt = c2 < c1;
    assign c  = lt ? c2 : c1;
    assign d  = lt ? d2 : d1;
endmodule

// File: rtl/disp_wta_seq.sv
// disp_wta_seq: serial winner-take-all disparity selector folding one cost per handshake
// through a single comparator and presenting the argmin on a valid/ready output.
module disp_wta_seq
    import disp_wta_seq_pkg::*;
#(
    parameter int WC = WC_DEF,
    parameter int WH = WH_DEF,
    parameter int D  = D_DEF,
    localparam int CBIT = cost_bits(WC, WH),
    localparam int DBIT = disp_bits(D)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cost_valid,
    output logic            o_cost_ready,
    input  logic [CBIT-1:0] i_cost,
    input  logic            i_cost_last,
    output logic            o_disp_valid,
    input  logic            i_disp_ready,
    output logic [DBIT-1:0] o_disp,
    output logic [CBIT-1:0] o_cost,
    output logic            o_err,
    output logic            o_busy
);
    state_t          state, state_nxt;
    logic [DBIT-1:0] cnt, best_d, cmp_d, fold_d;
    logic [CBIT-1:0] best_c, cmp_c, fold_c;
    logic            hs, at_end, end_px;

    disp_cmp #(.WC(WC), .WH(WH), .D(D)) u_cmp (
        .c1(best_c),
        .d1(best_d),
        .c2(i_cost),
        .d2(cnt),
        .c (cmp_c),
        .d (cmp_d)
    );

    // Ready passes through in OUT so the next pixel can start as the result drains.
    assign o_cost_ready = (state == ACCUM) ? 1'b1 : i_disp_ready;
    assign hs           = i_cost_valid && o_cost_ready;
    assign at_end       = cnt == DBIT'(D - 1);
    assign end_px       = hs && (at_end || i_cost_last);
    assign fold_c       = (cnt == '0) ? i_cost : cmp_c;
    assign fold_d       = (cnt == '0) ? '0 : cmp_d;
    assign o_busy       = (cnt != '0) || (state == OUT);

    always_comb begin
        state_nxt = state;
        if (end_px)
            state_nxt = OUT;
        else if (hs || (state == OUT && i_disp_ready))
            state_nxt = ACCUM;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            best_c       <= '0;
            best_d       <= '0;
            o_disp_valid <= 1'b0;
            o_disp       <= '0;
            o_cost       <= '0;
            o_err        <= 1'b0;
        end else begin
            if (hs) begin
                best_c <= fold_c;
                best_d <= fold_d;
            end
            if (end_px) begin
                o_disp <= fold_d;
                o_cost <= fold_c;
                cnt    <= '0;
            end else if (hs) begin
                cnt <= cnt + DBIT'(1);
            end
            // Valid is only ever set at end of pixel; any ready cycle otherwise drains it.
            if (end_px)
                o_disp_valid <= 1'b1;
            else if (i_disp_ready)
                o_disp_valid <= 1'b0;
            if (hs && (i_cost_last != at_end))
                o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_disp_wta_seq.sv
// tb_disp_wta_seq: directed vectors for disp_wta_seq (D=4) checked every cycle against
// a pixel-level argmin model, plus hand-computed literal expectations.
module tb_disp_wta_seq;
    import disp_wta_seq_pkg::*;
    localparam int D    = 4;
    localparam int CBIT = cost_bits(3, 7);
    localparam int DBIT = disp_bits(D);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cost_valid = 1'b0, cost_last = 1'b0, disp_ready = 1'b0;
    logic [CBIT-1:0] cost = '0;
    logic            cost_ready, disp_valid, err, busy;
    logic [DBIT-1:0] disp;
    logic [CBIT-1:0] res_cost;

    int n_vec = 0;
    int n_bad = 0;

    disp_wta_seq #(.WC(3), .WH(7), .D(D)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cost_valid(cost_valid),
        .o_cost_ready(cost_ready),
        .i_cost      (cost),
        .i_cost_last (cost_last),
        .o_disp_valid(disp_valid),
        .i_disp_ready(disp_ready),
        .o_disp      (disp),
        .o_cost      (res_cost),
        .o_err       (err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: whole-pixel view, costs gathered into a queue and argmin taken on completion.
    int q[$];
    bit m_valid, m_err, m_rdy, m_hs, m_full;
    int m_disp, m_cost;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid = 0; m_err = 0; m_disp = 0; m_cost = 0;
        end else begin
            m_rdy = !m_valid || disp_ready;
            m_hs  = cost_valid && m_rdy;
            if (m_valid && disp_ready) m_valid = 0;
            if (m_hs) begin
                q.push_back(int'(cost));
                m_full = q.size() == D;
                if (m_full || cost_last) begin
                    if (m_full != cost_last) m_err = 1;
                    m_disp = 0;
                    m_cost = q[0];
                    for (int i = 1; i < q.size(); i++)
                        if (q[i] < m_cost) begin m_cost = q[i]; m_disp = i; end
                    m_valid = 1;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cost_ready", int'(cost_ready), int'(!m_valid || disp_ready));
        chk("disp_valid", int'(disp_valid), int'(m_valid));
        chk("disp", int'(disp), m_disp);
        chk("cost", int'(res_cost), m_cost);
        chk("err", int'(err), int'(m_err));
        chk("busy", int'(busy), int'(q.size() != 0 || m_valid));
    end

    task automatic step(input bit v, input int c, input bit l, input bit r);
        cost_valid = v; cost = CBIT'(c); cost_last = l; disp_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string name, input int c0, c1, c2, c3, input int ed, ec);
        step(1, c0, 0, 1); step(1, c1, 0, 1); step(1, c2, 0, 1); step(1, c3, 1, 1);
        chk({name, "_valid"}, int'(disp_valid), 1);
        chk({name, "_disp"}, int'(disp), ed);
        chk({name, "_cost"}, int'(res_cost), ec);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", int'(disp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cost_ready), 1);
        step(0, 0, 0, 1);

        pix("p1", 40, 12, 30, 25, 1, 12);
        chk("p1_err", int'(err), 0);
        step(0, 0, 0, 1);
        chk("p1_one_cycle", int'(disp_valid), 0);

        pix("tie_a", 7, 9, 7, 7, 0, 7);
        pix("tie_b", 9, 5, 5, 6, 1, 5);
        step(0, 0, 0, 1);

        // Backpressure: result held five cycles while the next cost waits.
        step(1, 20, 0, 1); step(1, 8, 0, 1); step(1, 8, 0, 1); step(1, 3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 11, 0, 0);
            chk("bp_hold_ready", int'(cost_ready), 0);
            chk("bp_hold_valid", int'(disp_valid), 1);
            chk("bp_hold_disp", int'(disp), 3);
            chk("bp_hold_cost", int'(res_cost), 3);
        end
        step(1, 11, 0, 1);
        chk("bp_consumed", int'(disp_valid), 0);
        chk("bp_busy", int'(busy), 1);
        step(1, 6, 0, 1); step(1, 11, 0, 1); step(1, 2, 1, 1);
        chk("bp_next_disp", int'(disp), 3);
        chk("bp_next_cost", int'(res_cost), 2);

        pix("b2b_a", 3, 2, 1, 0, 3, 0);
        pix("b2b_b", 5, 1, 4, 1, 1, 1);
        pix("b2b_c", 2, 2, 2, 2, 0, 2);

        step(1, 50, 0, 1); step(1, 10, 1, 1);
        chk("early_disp", int'(disp), 1);
        chk("early_cost", int'(res_cost), 10);
        chk("early_err", int'(err), 1);
        pix("after_early", 8, 4, 6, 9, 1, 4);
        chk("err_sticky", int'(err), 1);

        // Missing last: pixel still ends at index D-1.
        step(1, 6, 0, 1); step(1, 6, 0, 1); step(1, 1, 0, 1); step(1, 6, 0, 1);
        chk("miss_valid", int'(disp_valid), 1);
        chk("miss_disp", int'(disp), 2);

        // Mid-pixel asynchronous reset.
        step(1, 5, 0, 1); step(1, 3, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_disp", int'(disp), 0);
        chk("arst_cost", int'(res_cost), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pix("post_rst", 1, 2, 3, 0, 3, 0);
        chk("post_rst_err", int'(err), 0);

        // Reset while a result is pending.
        step(1, 4, 0, 0); step(1, 4, 0, 0); step(1, 4, 0, 0); step(1, 4, 1, 0);
        step(0, 0, 0, 0);
        chk("pend_valid", int'(disp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("pend_rst_valid", int'(disp_valid), 0);
        chk("pend_rst_busy", int'(busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pix("post_pend", 9, 9, 8, 9, 2, 8);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
